// File: rtl/memctrl_arb.sv
// rtl/memctrl_arb.sv - two-port arbiter and 4-phase access sequencer for MEMCTRL
module memctrl_arb #(
   parameter int AW         = 16,
   parameter int DW         = 8,
   parameter int FIXED_PRIO = 0
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          P0_VALID,
   output logic          P0_READY,
   input  logic          P0_WE,
   input  logic [AW-1:0] P0_ADDR,
   input  logic [DW-1:0] P0_WDATA,
   input  logic          P1_VALID,
   output logic          P1_READY,
   input  logic          P1_WE,
   input  logic [AW-1:0] P1_ADDR,
   input  logic [DW-1:0] P1_WDATA,
   output logic          RSP_VALID,
   output logic          RSP_ID,
   output logic          RSP_WE,
   output logic [DW-1:0] RSP_RDATA,
   input  logic          BIST_EN,
   output logic          BUSY,
   output logic [AW-1:0] MEM_ADDR,
   output logic          MEM_CE,
   output logic          MEM_CSB,
   output logic [DW-1:0] MEM_IDATA,
   output logic          MEM_OEB,
   output logic          MEM_WEB,
   input  logic [DW-1:0] MEM_ODATA
);

   typedef enum logic [2:0] {IDLE, S_CE, S_SEL, S_HOLD, S_REL} state_t;

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          we_q, we_d;
   logic          id_q, id_d;
   logic          ce_q, ce_d;
   logic          csb_q, csb_d;
   logic          web_q, web_d;
   logic          oeb_q, oeb_d;
   logic [DW-1:0] idata_q, idata_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_id_q, rsp_id_d;
   logic          rsp_we_q, rsp_we_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          grant;
   logic          can_accept;
   logic          xfer;

   // Arbitration: a lone requester wins; a tie goes to port 0 (fixed) or the port not served last.
   always_comb begin
      grant = 1'b0;
      if (P1_VALID && !P0_VALID) begin
         grant = 1'b1;
      end else if (P0_VALID && P1_VALID && (FIXED_PRIO == 0)) begin
         grant = ~last_q;
      end
   end

   // Handshake is combinational; nothing is accepted while BIST owns the memory or under reset.
   assign can_accept = (state_q == IDLE) && !BIST_EN && !RST;
   assign P0_READY   = can_accept && P0_VALID && !grant;
   assign P1_READY   = can_accept && P1_VALID && grant;
   assign xfer       = P0_READY || P1_READY;
   assign BUSY       = (state_q != IDLE);

   // Next state, request latching and the registered strobe values for the state being entered.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      id_d        = id_q;
      ce_d        = 1'b0;
      csb_d       = 1'b1;
      web_d       = 1'b1;
      oeb_d       = 1'b1;
      idata_d     = '0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_we_d    = rsp_we_q;
      rdata_d     = rdata_q;

      case (state_q)
         IDLE: begin
            if (xfer) begin
               state_d = S_CE;
               last_d  = grant;
               id_d    = grant;
               addr_d  = grant ? P1_ADDR  : P0_ADDR;
               wdata_d = grant ? P1_WDATA : P0_WDATA;
               we_d    = grant ? P1_WE    : P0_WE;
            end
         end
         S_CE:    state_d = S_SEL;
         S_SEL:   state_d = S_HOLD;
         S_HOLD:  state_d = S_REL;
         S_REL:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      case (state_d)
         S_CE: begin
            ce_d = 1'b1;
         end
         S_SEL: begin
            ce_d    = 1'b1;
            csb_d   = 1'b0;
            web_d   = ~we_d;
            oeb_d   = we_d;
            idata_d = we_d ? wdata_d : '0;
         end
         S_HOLD: begin
            csb_d   = 1'b0;
            web_d   = ~we_d;
            oeb_d   = we_d;
            idata_d = we_d ? wdata_d : '0;
         end
         S_REL: begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_we_d    = we_q;
         end
         default: ;
      endcase

      // Read data is captured on the edge leaving S_HOLD and held across writes.
      if ((state_q == S_HOLD) && !we_q) begin
         rdata_d = MEM_ODATA;
      end
   end

   // State and output registers; reset drops any in-flight access.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         id_q        <= 1'b0;
         ce_q        <= 1'b0;
         csb_q       <= 1'b1;
         web_q       <= 1'b1;
         oeb_q       <= 1'b1;
         idata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_we_q    <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         id_q        <= id_d;
         ce_q        <= ce_d;
         csb_q       <= csb_d;
         web_q       <= web_d;
         oeb_q       <= oeb_d;
         idata_q     <= idata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_we_q    <= rsp_we_d;
         rdata_q     <= rdata_d;
      end
   end

   assign MEM_ADDR  = addr_q;
   assign MEM_CE    = ce_q;
   assign MEM_CSB   = csb_q;
   assign MEM_WEB   = web_q;
   assign MEM_OEB   = oeb_q;
   assign MEM_IDATA = idata_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_ID    = rsp_id_q;
   assign RSP_WE    = rsp_we_q;
   assign RSP_RDATA = rdata_q;

endmodule

// File: tb/tb_memctrl_arb.sv
// tb/tb_memctrl_arb.sv - scoreboard bench for memctrl_arb with an SRAM model behind MEM_*
module tb_memctrl_arb;

   typedef struct packed {
      logic       id;
      logic       we;
      logic [7:0] rd;
   } rsp_t;

   logic        clk, rst, bist_en;
   logic        p0_valid, p0_ready, p0_we, p1_valid, p1_ready, p1_we;
   logic [15:0] p0_addr, p1_addr;
   logic [7:0]  p0_wdata, p1_wdata;
   logic        rsp_valid, rsp_id, rsp_we, busy;
   logic [7:0]  rsp_rdata;
   logic [15:0] mem_addr;
   logic        mem_ce, mem_csb, mem_oeb, mem_web;
   logic [7:0]  mem_idata, mem_odata;

   logic        f_p0_valid, f_p0_ready, f_p1_valid, f_p1_ready;
   logic        f_zero;
   logic [15:0] f_addr;
   logic [7:0]  f_data;
   logic        f_rsp_valid, f_rsp_id, f_rsp_we, f_busy;
   logic [7:0]  f_rsp_rdata, f_mem_idata;
   logic [15:0] f_mem_addr;
   logic        f_mem_ce, f_mem_csb, f_mem_oeb, f_mem_web;

   rsp_t        sb_q[$];
   rsp_t        mon_e;
   int          n_vec = 0;
   int          n_miss = 0;
   logic [7:0]  mem    [0:255];
   logic [7:0]  shadow [0:255];
   logic [7:0]  exp_last_rd;
   logic        prev_csb, prev_ce, prev_web, prev_oeb;
   logic [15:0] prev_addr;
   logic [7:0]  prev_idata;

   memctrl_arb #(.AW(16), .DW(8), .FIXED_PRIO(0)) dut (
      .CLK(clk), .RST(rst),
      .P0_VALID(p0_valid), .P0_READY(p0_ready), .P0_WE(p0_we), .P0_ADDR(p0_addr), .P0_WDATA(p0_wdata),
      .P1_VALID(p1_valid), .P1_READY(p1_ready), .P1_WE(p1_we), .P1_ADDR(p1_addr), .P1_WDATA(p1_wdata),
      .RSP_VALID(rsp_valid), .RSP_ID(rsp_id), .RSP_WE(rsp_we), .RSP_RDATA(rsp_rdata),
      .BIST_EN(bist_en), .BUSY(busy),
      .MEM_ADDR(mem_addr), .MEM_CE(mem_ce), .MEM_CSB(mem_csb), .MEM_IDATA(mem_idata),
      .MEM_OEB(mem_oeb), .MEM_WEB(mem_web), .MEM_ODATA(mem_odata)
   );

   memctrl_arb #(.AW(16), .DW(8), .FIXED_PRIO(1)) dut_fp (
      .CLK(clk), .RST(rst),
      .P0_VALID(f_p0_valid), .P0_READY(f_p0_ready), .P0_WE(f_zero), .P0_ADDR(f_addr), .P0_WDATA(f_data),
      .P1_VALID(f_p1_valid), .P1_READY(f_p1_ready), .P1_WE(f_zero), .P1_ADDR(f_addr), .P1_WDATA(f_data),
      .RSP_VALID(f_rsp_valid), .RSP_ID(f_rsp_id), .RSP_WE(f_rsp_we), .RSP_RDATA(f_rsp_rdata),
      .BIST_EN(f_zero), .BUSY(f_busy),
      .MEM_ADDR(f_mem_addr), .MEM_CE(f_mem_ce), .MEM_CSB(f_mem_csb), .MEM_IDATA(f_mem_idata),
      .MEM_OEB(f_mem_oeb), .MEM_WEB(f_mem_web), .MEM_ODATA(f_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: write while selected with WEB low, asynchronous read
   always @(posedge clk) begin
      if (mem_csb === 1'b0 && mem_web === 1'b0) mem[mem_addr[7:0]] <= mem_idata;
   end
   assign mem_odata = mem[mem_addr[7:0]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Response scoreboard and pin-interface ordering monitor
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("rsp_id", rsp_id, mon_e.id);
            chk("rsp_we", rsp_we, mon_e.we);
            chk("rsp_rdata", rsp_rdata, mon_e.rd);
         end
      end
      if (prev_csb === 1'b0 && mem_csb === 1'b0) begin
         chk("addr_stable", mem_addr, prev_addr);
         chk("web_stable", mem_web, prev_web);
         chk("oeb_stable", mem_oeb, prev_oeb);
         chk("idata_stable", mem_idata, prev_idata);
      end
      if (prev_csb === 1'b1 && mem_csb === 1'b0) chk("ce_before_csb_fall", {prev_ce, mem_ce}, 2'b11);
      if (prev_csb === 1'b0 && mem_csb === 1'b1) chk("ce_low_before_csb_rise", prev_ce, 0);
      prev_csb   = mem_csb;
      prev_ce    = mem_ce;
      prev_web   = mem_web;
      prev_oeb   = mem_oeb;
      prev_addr  = mem_addr;
      prev_idata = mem_idata;
   end

   task automatic issue(input bit port, input bit we, input logic [15:0] addr, input logic [7:0] wd);
      int   n;
      rsp_t e;
      if (port) begin
         p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
      end else begin
         p0_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
      end
      n = 0;
      #1;
      while (((port ? p1_ready : p0_ready) !== 1'b1) && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("accept_timeout", n < 50, 1);
      e.id = port;
      e.we = we;
      if (we) begin
         shadow[addr[7:0]] = wd;
         e.rd = exp_last_rd;
      end else begin
         e.rd = shadow[addr[7:0]];
         exp_last_rd = e.rd;
      end
      sb_q.push_back(e);
      @(negedge clk);
      p0_valid = 1'b0;
      p1_valid = 1'b0;
   endtask

   // Called at the negedge of the S_CE cycle; walks S_CE..IDLE
   task automatic check_seq(input bit we, input logic [15:0] addr, input logic [7:0] wd);
      logic [3:0] exp_s;
      for (int k = 0; k < 5; k++) begin
         case (k)
            0:       exp_s = 4'b1111;
            1:       exp_s = {1'b1, 1'b0, ~we, we};
            2:       exp_s = {1'b0, 1'b0, ~we, we};
            default: exp_s = 4'b0111;
         endcase
         chk("strobes", {mem_ce, mem_csb, mem_web, mem_oeb}, exp_s);
         chk("mem_addr", mem_addr, addr);
         chk("mem_idata", mem_idata, (we && (k == 1 || k == 2)) ? wd : 8'h00);
         chk("rsp_valid_timing", rsp_valid, k == 3);
         chk("busy", busy, k < 4);
         @(negedge clk);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         got, fgot, cyc, last_acc, flast, n;
      logic [7:0] rnd;
      rsp_t       e;

      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'h00;
         shadow[i] = 8'h00;
      end
      exp_last_rd = 8'h00;
      rst = 1'b1; bist_en = 1'b0;
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 16'h0000; p0_wdata = 8'h00;
      p1_valid = 1'b0; p1_we = 1'b0; p1_addr = 16'h0000; p1_wdata = 8'h00;
      f_p0_valid = 1'b0; f_p1_valid = 1'b0; f_zero = 1'b0; f_addr = 16'h0012; f_data = 8'h00;

      // Reset held with a request pending
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("rst_ready", p0_ready, 0);
         chk("rst_strobes", {mem_ce, mem_csb, mem_oeb, mem_web}, 4'b0111);
         chk("rst_addr", mem_addr, 0);
         chk("rst_busy", busy, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      p0_valid = 1'b0;
      @(negedge clk);

      // Single write then read with full strobe sequence
      issue(0, 1, 16'h0012, 8'hA5);
      check_seq(1, 16'h0012, 8'hA5);
      issue(0, 0, 16'h0012, 8'h00);
      check_seq(0, 16'h0012, 8'h00);
      chk("rdata_held", rsp_rdata, 8'hA5);

      // Tie: round-robin on dut, fixed priority on dut_fp, both fresh from reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_last_rd = 8'h00;
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 16'h0012;
      p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 16'h0012;
      f_p0_valid = 1'b1; f_p1_valid = 1'b1;
      got = 0; fgot = 0; cyc = 0; last_acc = 0; flast = 0;
      while ((got < 4 || fgot < 4) && cyc < 100) begin
         #1;
         if ((p0_ready || p1_ready) && got < 4) begin
            chk("tie_single_grant", p0_ready & p1_ready, 0);
            chk("tie_grant_rr", p1_ready, got % 2);
            if (got > 0) chk("tie_gap_rr", cyc - last_acc, 5);
            e.id = p1_ready; e.we = 1'b0; e.rd = shadow[8'h12];
            exp_last_rd = e.rd;
            sb_q.push_back(e);
            last_acc = cyc;
            got++;
         end
         if ((f_p0_ready || f_p1_ready) && fgot < 4) begin
            chk("tie_grant_fp", f_p1_ready, 0);
            if (fgot > 0) chk("tie_gap_fp", cyc - flast, 5);
            flast = cyc;
            fgot++;
         end
         @(negedge clk);
         cyc++;
         if (got == 4) begin p0_valid = 1'b0; p1_valid = 1'b0; end
         if (fgot == 4) begin f_p0_valid = 1'b0; f_p1_valid = 1'b0; end
      end
      chk("tie_count_rr", got, 4);
      chk("tie_count_fp", fgot, 4);
      repeat (6) @(negedge clk);

      // BIST rises in S_SEL of a P1 write
      issue(1, 1, 16'h0040, 8'h3C);
      @(negedge clk);
      bist_en = 1'b1;
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 16'h0040;
      #1;
      chk("bist_sel_ready", p0_ready, 0);
      @(negedge clk);
      chk("bist_hold_rsp", rsp_valid, 0);
      @(negedge clk);
      chk("bist_rsp", rsp_valid, 1);
      repeat (6) begin
         @(negedge clk);
         #1;
         chk("bist_p0_ready", p0_ready, 0);
         chk("bist_busy", busy, 0);
      end
      @(negedge clk);
      bist_en = 1'b0;
      #1;
      chk("bist_release_ready", p0_ready, 1);
      e.id = 1'b0; e.we = 1'b0; e.rd = shadow[8'h40];
      exp_last_rd = e.rd;
      sb_q.push_back(e);
      @(negedge clk);
      p0_valid = 1'b0;
      repeat (6) @(negedge clk);

      // Reset pulsed during S_HOLD of a read
      p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 16'h0012;
      #1;
      chk("rst_mid_accept", p0_ready, 1);
      @(negedge clk);
      p0_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_in_hold", {mem_ce, mem_csb}, 2'b00);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_strobes", {mem_ce, mem_csb, mem_oeb, mem_web}, 4'b0111);
      chk("rst_mid_addr", mem_addr, 0);
      chk("rst_mid_idata", mem_idata, 0);
      chk("rst_mid_rsp_valid", rsp_valid, 0);
      chk("rst_mid_rdata", rsp_rdata, 0);
      chk("rst_mid_busy", busy, 0);
      rst = 1'b0;
      exp_last_rd = 8'h00;
      repeat (5) begin
         @(negedge clk);
         chk("rst_mid_no_rsp", rsp_valid, 0);
      end

      // Back-to-back sweep
      for (int i = 0; i < 100; i++) begin
         rnd = 8'($urandom);
         issue(0, 1, 16'(i), rnd);
      end
      for (int i = 0; i < 100; i++) begin
         issue(0, 0, 16'(i), 8'h00);
      end

      n = 0;
      while (sb_q.size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("sb_drain", sb_q.size(), 0);
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/memctrl_arb.md
# memctrl_arb

Two-requester arbiter and access sequencer in front of `MEMCTRL`. It owns the `MEMCTRL` pin interface (`ADDR`, `CE`, `CSB`, `IDATA`, `OEB`, `WEB`, `ODATA`) and shares it between port 0 (host) and port 1 (scrub/DMA). Each accepted request becomes one fixed 4-phase CE/CSB strobe sequence. While `BIST_EN` is high, `MEMCTRL` belongs to its internal BIST, so no new grants are issued.

## Interface
Parameters:
- `AW`, 16: address width.
- `DW`, 8: data width.
- `FIXED_PRIO`, 0: 0 = round-robin; 1 = port 0 always wins.

Ports:
- `CLK` in 1: clock; all state is updated on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `P0_VALID` / `P1_VALID` in 1: request valid.
- `P0_READY` / `P1_READY` out 1: request accepted this cycle.
- `P0_WE` / `P1_WE` in 1: 1 = write, 0 = read.
- `P0_ADDR` / `P1_ADDR` in AW: request address.
- `P0_WDATA` / `P1_WDATA` in DW: write data.
- `RSP_VALID` out 1: one-cycle completion pulse.
- `RSP_ID` out 1: port that issued the completed access.
- `RSP_WE` out 1: completed access was a write.
- `RSP_RDATA` out DW: read data; held until the next read completes.
- `BIST_EN` in 1: blocks new grants.
- `BUSY` out 1: high whenever state is not IDLE.
- `MEM_ADDR` out AW, `MEM_CE` out 1, `MEM_CSB` out 1, `MEM_IDATA` out DW, `MEM_OEB` out 1, `MEM_WEB` out 1: drive `MEMCTRL`.
- `MEM_ODATA` in DW: read data from `MEMCTRL`.

## Operation
- FSM states: IDLE -> S_CE -> S_SEL -> S_HOLD -> S_REL -> IDLE.
- There are no other transitions. An access cannot be aborted except by `RST`.
- **Accept (IDLE only):**
  - `Pn_READY = (state==IDLE) & !BIST_EN & Pn_VALID & grant==n`; this term is combinational.
  - A transfer happens when VALID & READY are both high.
  - On a transfer, latch addr/wdata/we/id and go to S_CE.
- **Arbitration:**
  - With one requester, that requester is granted.
  - With both requesting and `FIXED_PRIO=0`, grant the port not granted last. The `last` pointer is set to 1 at reset, so port 0 wins the first tie.
  - With `FIXED_PRIO=1`, port 0 always wins.
  - `last` updates only on a transfer.
- **Registered strobe values per state** (CE, CSB, WEB, OEB):
  - IDLE: 0, 1, 1, 1.
  - S_CE: 1, 1, 1, 1.
  - S_SEL: 1, 0, !we, we.
  - S_HOLD: 0, 0, !we, we.
  - S_REL: 0, 1, 1, 1.
- **`MEM_ADDR`:** equals the latched address from S_CE through S_REL. In IDLE it holds its last value (0 after reset).
- **`MEM_IDATA`:** equals wdata in S_SEL and S_HOLD for writes; 0 in all other states and for reads.
- **Read capture:** `MEM_ODATA` is sampled into `RSP_RDATA` on the edge leaving S_HOLD.
- **Completion:** in S_REL, `RSP_VALID=1`, `RSP_ID`=latched id, `RSP_WE`=latched we.
- **`BIST_EN` rising mid-access:** the access completes normally, then the FSM stays in IDLE with both READY signals low until `BIST_EN` falls.
- **`RST` at any state:**
  - FSM -> IDLE; outputs take IDLE values.
  - `MEM_ADDR`=0, `MEM_IDATA`=0, `RSP_*`=0, `last`=1.
  - The in-flight access is dropped with no `RSP_VALID`.
  - READY is 0 while `RST` is high.

## Timing
- Accept-to-accept spacing is 5 cycles, so peak throughput is one access per 5 CLK.
- Transfer at edge T0:
  - S_CE is the cycle after T0.
  - `MEM_CSB` falls one cycle later (S_SEL).
  - `MEM_CE` falls in S_HOLD.
  - `RSP_VALID` is high in the 4th cycle after T0.
  - The next READY is possible in the 5th cycle.
- Ordering guarantees:
  - `MEM_CE` rises one full cycle before `MEM_CSB` falls.
  - `MEM_CSB` rises one cycle after `MEM_CE` falls.
  - `WEB`/`OEB`/`ADDR`/`IDATA` are stable throughout the CSB-low window.
- All `MEM_*` and `RSP_*` outputs are flops. Only `Pn_READY` and `BUSY` are combinational.
- A requester that holds VALID must hold ADDR/WE/WDATA unchanged until READY.

## Test plan
- **Reset:** `RST=1` for 3 cycles, `P0_VALID=1` -> READY 0 throughout; MEM CE=0, CSB=1, OEB=1, WEB=1, ADDR=0; `BUSY`=0.
- **Single write then read:**
  - Stimulus: P0 writes `ADDR=16'h0012`, WDATA=8'hA5; then P0 reads `16'h0012`; bench SRAM model behind `MEM_*`.
  - Required strobe sequence matches the Operation state list exactly.
  - Read response: `RSP_VALID` with `RSP_WE=0`, `RSP_ID=0`, `RSP_RDATA=8'hA5`.
- **Tie:** P0 and P1 both hold VALID for 4 accesses, `FIXED_PRIO=0` -> grants P0,P1,P0,P1, accepts 5 cycles apart; with `FIXED_PRIO=1` -> P0 ×4.
- **BIST block:** `BIST_EN` rises in S_SEL of a P1 write -> write completes with `RSP_VALID` 2 cycles later; no READY while `BIST_EN=1`; first READY in the cycle `BIST_EN` is seen low.
- **Reset mid-access:** `RST` pulsed during S_HOLD of a read -> next cycle IDLE values on all MEM outputs, no `RSP_VALID`, `RSP_RDATA=0`.
- **Back-to-back sweep:**
  - Stimulus: 100 P0 writes to addresses 0..99 with random data, then 100 reads of the same addresses.
  - Every read's `RSP_RDATA` matches its written value.
  - `MEM_ADDR` never changes while `MEM_CSB=0`.
